// File: rtl/fb_arb_pkg.sv
// Shared constants, slot-state encoding and address helper for the framebuffer port arbiter.
package fb_arb_pkg;

  localparam int FB_W         = 300;
  localparam int FB_H         = 400;
  localparam int ADDR_W       = 17;
  localparam int COLOR_W      = 24;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int STARVE_LIMIT = 16;
  localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } slot_state_t;

  // Travels alongside each display request until its pixel is delivered.
  typedef struct packed {
    logic valid;
    logic blank;
    logic miss;
  } disp_tag_t;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(FB_W);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Linear framebuffer address (x + y*FB_W) and in-range flag for one requester.
module fb_addr_gen
  import fb_arb_pkg::*;
(
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  assign addr     = fb_addr(x, y);
  assign in_range = (x < X_W'(FB_W)) && (y < Y_W'(FB_H));

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads outrank writer stores.
// Optional writer starvation guard enabled by defining FB_ARB_STARVE_GUARD_EN.
module fb_port_arbiter
  import fb_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               disp_req,
  input  logic [X_W-1:0]     disp_x,
  input  logic [Y_W-1:0]     disp_y,
  output logic [COLOR_W-1:0] disp_color,
  output logic               disp_valid,
  output logic               disp_miss,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [X_W-1:0]     wr_x,
  input  logic [Y_W-1:0]     wr_y,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_err,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);

  logic [ADDR_W-1:0] disp_addr, wr_addr;
  logic              disp_in_range, wr_in_range;
  logic              guard_grant, disp_grant, wr_xfer, rd_issue, wr_issue;
  slot_state_t       state, next_state;
  disp_tag_t         tag_s1, tag_s2;

  fb_addr_gen u_disp_addr (.x(disp_x), .y(disp_y), .addr(disp_addr), .in_range(disp_in_range));
  fb_addr_gen u_wr_addr   (.x(wr_x),   .y(wr_y),   .addr(wr_addr),   .in_range(wr_in_range));

`ifdef FB_ARB_STARVE_GUARD_EN
  logic [STARVE_W-1:0] starve_cnt;

  // Reaching the limit forces one writer slot; the counter then clears.
  assign guard_grant = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    starve_cnt <= '0;
    else if (!wr_valid || wr_xfer) starve_cnt <= '0;
    else                           starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign guard_grant = 1'b0;
`endif

  assign disp_grant = disp_req && !guard_grant;
  assign wr_ready   = rst_n && !disp_grant;
  assign wr_xfer    = wr_valid && wr_ready;
  assign rd_issue   = disp_grant && disp_in_range;
  assign wr_issue   = wr_xfer && wr_in_range;

  // NOTE: default assignment first, so no path through always_comb can infer a latch.
  always_comb begin
    next_state = IDLE;
    if (rd_issue)      next_state = RD;
    else if (wr_issue) next_state = WR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  assign mem_we = (state == WR);

  // Address and data hold their last values through idle and dropped slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= wr_xfer && !wr_in_range;
      if (rd_issue) begin
        mem_addr <= disp_addr;
      end else if (wr_issue) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

  // NOTE: only control/valid state needs reset for correctness; data here is reset
  // too because its post-reset value is externally visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s1     <= '0;
      tag_s2     <= '0;
      disp_valid <= 1'b0;
      disp_miss  <= 1'b0;
      disp_color <= '0;
    end else begin
      tag_s1     <= '{valid: disp_req,
                      blank: disp_grant && !disp_in_range,
                      miss:  disp_req && guard_grant};
      tag_s2     <= tag_s1;
      disp_valid <= tag_s2.valid;
      disp_miss  <= tag_s2.valid && tag_s2.miss;
      // A missed slot repeats whatever colour was delivered last.
      if (tag_s2.valid && !tag_s2.miss)
        disp_color <= tag_s2.blank ? '0 : mem_rdata;
    end
  end

endmodule
